vx_mem_perf_monitor: RTL

//  Parametrised per-core memory performance monitor generalising the core's inline ifetch/load/store perf logic.

---
 rtl/vx_mem_perf_monitor_pkg.sv | 15 +
 rtl/vx_mem_perf_monitor_if.sv | 33 +++
 rtl/vx_mem_perf_monitor_sat_ctr.sv | 38 +++
 rtl/vx_mem_perf_monitor.sv | 118 +++++++++++
 4 files changed

// File: rtl/vx_mem_perf_monitor_pkg.sv
// Shared types and defaults for the per-port memory performance monitor.
// The struct bundles the four event counters for hookup into pipeline perf aggregation.
package vx_mem_perf_monitor_pkg;

   localparam int PERF_CTR_BITS  = 44;
   localparam int PEND_WIDTH_DEF = 16;

   typedef struct packed {
      logic [PERF_CTR_BITS-1:0] reads;
      logic [PERF_CTR_BITS-1:0] writes;
      logic [PERF_CTR_BITS-1:0] rsps;
      logic [PERF_CTR_BITS-1:0] latency;
   } mem_perf_mon_t;

endpackage

// File: rtl/vx_mem_perf_monitor_if.sv
// Handshake sample inputs and counter outputs of the memory performance monitor.
// The master side drives the per-lane fires and control; the monitor is the slave.
interface vx_mem_perf_monitor_if #(
   parameter int NUM_CHANNELS = 4,
   parameter int CTR_WIDTH    = 44,
   parameter int PEND_WIDTH   = 16
);
   logic                    enable;
   logic                    clear;
   logic [NUM_CHANNELS-1:0] req_fire;
   logic [NUM_CHANNELS-1:0] req_rw;
   logic [NUM_CHANNELS-1:0] rsp_fire;
   logic [CTR_WIDTH-1:0]    perf_reads;
   logic [CTR_WIDTH-1:0]    perf_writes;
   logic [CTR_WIDTH-1:0]    perf_rsps;
   logic [CTR_WIDTH-1:0]    perf_latency;
   logic [PEND_WIDTH-1:0]   pending_reads;
   logic [PEND_WIDTH-1:0]   pending_max;
   logic                    sat_flag;
   logic                    underflow_flag;

   modport master (
      output enable, clear, req_fire, req_rw, rsp_fire,
      input  perf_reads, perf_writes, perf_rsps, perf_latency,
      input  pending_reads, pending_max, sat_flag, underflow_flag
   );

   modport slave (
      input  enable, clear, req_fire, req_rw, rsp_fire,
      output perf_reads, perf_writes, perf_rsps, perf_latency,
      output pending_reads, pending_max, sat_flag, underflow_flag
   );
endinterface

// File: rtl/vx_mem_perf_monitor_sat_ctr.sv
// Saturating accumulator: adds inc_i when enabled, clamps at all-ones and flags the overflow.
// clear_i wins over enable_i and discards that cycle's increment.
module vx_mem_perf_monitor_sat_ctr #(
   parameter int WIDTH     = 44,
   parameter int INC_WIDTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 enable_i,
   input  logic [INC_WIDTH-1:0] inc_i,
   output logic [WIDTH-1:0]     count_o,
   output logic                 sat_o
);
   // One extra bit over the wider operand so the carry is never lost.
   localparam int SW = ((WIDTH > INC_WIDTH) ? WIDTH : INC_WIDTH) + 1;

   logic [WIDTH-1:0] count_q, count_d;
   logic [SW-1:0]    sum;
   logic             ovf;

   assign sum   = SW'(count_q) + SW'(inc_i);
   assign ovf   = (sum > SW'({WIDTH{1'b1}}));
   assign sat_o = enable_i & ~clear_i & ovf;

   always_comb begin
      count_d = count_q;
      if (clear_i)       count_d = '0;
      else if (enable_i) count_d = ovf ? '1 : sum[WIDTH-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;
endmodule

// File: rtl/vx_mem_perf_monitor.sv
// Per-port memory perf monitor: stage 1 registers lane vectors, stage 2 popcounts and
// updates read/write/response/latency counters, outstanding reads and their high-water mark.
module vx_mem_perf_monitor
   import vx_mem_perf_monitor_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int CTR_WIDTH    = PERF_CTR_BITS,
   parameter int PEND_WIDTH   = PEND_WIDTH_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   vx_mem_perf_monitor_if.slave mon
);
   localparam int CW = $clog2(NUM_CHANNELS + 1);
   localparam int SW = PEND_WIDTH + 2;

   logic [NUM_CHANNELS-1:0] rd_vec_q, wr_vec_q, rsp_vec_q;
   logic                    en_q;
   logic [CW-1:0]           rd_cnt, wr_cnt, rsp_cnt;
   logic [PEND_WIDTH-1:0]   pending_q, pending_d, pending_max_q;
   logic signed [SW-1:0]    pend_sum;
   logic                    pend_uf, pend_sat;
   logic                    sat_q, uf_q;
   logic [3:0]              ctr_sat;
   logic [CTR_WIDTH-1:0]    reads, writes, rsps, latency;

   // Stage 1 samples every cycle; enable travels with the sample it qualifies.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_vec_q  <= '0;
         wr_vec_q  <= '0;
         rsp_vec_q <= '0;
         en_q      <= 1'b0;
      end else begin
         rd_vec_q  <= mon.req_fire & ~mon.req_rw;
         wr_vec_q  <= mon.req_fire &  mon.req_rw;
         rsp_vec_q <= mon.rsp_fire;
         en_q      <= mon.enable;
      end
   end

   always_comb begin
      rd_cnt  = '0;
      wr_cnt  = '0;
      rsp_cnt = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         rd_cnt  = rd_cnt  + CW'(rd_vec_q[i]);
         wr_cnt  = wr_cnt  + CW'(wr_vec_q[i]);
         rsp_cnt = rsp_cnt + CW'(rsp_vec_q[i]);
      end
   end

   assign pend_sum = $signed({2'b00, pending_q}) + $signed(SW'(rd_cnt)) - $signed(SW'(rsp_cnt));

   always_comb begin
      pending_d = pending_q;
      pend_uf   = 1'b0;
      pend_sat  = 1'b0;
      if (en_q) begin
         if (pend_sum < 0) begin
            pending_d = '0;
            pend_uf   = 1'b1;
         end else if (pend_sum > $signed(SW'({PEND_WIDTH{1'b1}}))) begin
            pending_d = '1;
            pend_sat  = 1'b1;
         end else begin
            pending_d = pend_sum[PEND_WIDTH-1:0];
         end
      end
   end

   // clear does not touch pending_q: those reads are still really in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q     <= '0;
         pending_max_q <= '0;
         sat_q         <= 1'b0;
         uf_q          <= 1'b0;
      end else begin
         pending_q <= pending_d;
         if (mon.clear) begin
            pending_max_q <= pending_d;
            sat_q         <= 1'b0;
            uf_q          <= 1'b0;
         end else begin
            if (pending_d > pending_max_q) pending_max_q <= pending_d;
            sat_q <= sat_q | pend_sat | (|ctr_sat);
            uf_q  <= uf_q | pend_uf;
         end
      end
   end

   vx_mem_perf_monitor_sat_ctr #(.WIDTH(CTR_WIDTH), .INC_WIDTH(CW)) u_reads (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(mon.clear), .enable_i(en_q),
      .inc_i(rd_cnt), .count_o(reads), .sat_o(ctr_sat[0]));

   vx_mem_perf_monitor_sat_ctr #(.WIDTH(CTR_WIDTH), .INC_WIDTH(CW)) u_writes (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(mon.clear), .enable_i(en_q),
      .inc_i(wr_cnt), .count_o(writes), .sat_o(ctr_sat[1]));

   vx_mem_perf_monitor_sat_ctr #(.WIDTH(CTR_WIDTH), .INC_WIDTH(CW)) u_rsps (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(mon.clear), .enable_i(en_q),
      .inc_i(rsp_cnt), .count_o(rsps), .sat_o(ctr_sat[2]));

   // Latency accumulates the pre-update outstanding count each counted cycle.
   vx_mem_perf_monitor_sat_ctr #(.WIDTH(CTR_WIDTH), .INC_WIDTH(PEND_WIDTH)) u_latency (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(mon.clear), .enable_i(en_q),
      .inc_i(pending_q), .count_o(latency), .sat_o(ctr_sat[3]));

   assign mon.perf_reads     = reads;
   assign mon.perf_writes    = writes;
   assign mon.perf_rsps      = rsps;
   assign mon.perf_latency   = latency;
   assign mon.pending_reads  = pending_q;
   assign mon.pending_max    = pending_max_q;
   assign mon.sat_flag       = sat_q;
   assign mon.underflow_flag = uf_q;
endmodule
